// File: rtl/div_unit.sv
// div_unit: multi-cycle restoring divider for DIV/DIVU/REM/REMU with register-file write-back
module div_unit (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [2:0]  funct3,
  input  logic [31:0] rs1_value,
  input  logic [31:0] rs2_value,
  input  logic [4:0]  rd_in,
  output logic        busy,
  output logic        done,
  output logic        wr_en,
  output logic [4:0]  rd_out,
  output logic [31:0] result
);
  typedef enum logic [1:0] {IDLE, CALC, FIN} state_t;
  state_t state, next_state;
  logic [4:0]  cnt, rd_q;
  logic [31:0] q, d, r, a_mag, b_mag, fin_q, fin_r;
  logic [32:0] shifted, diff;
  logic        is_rem, neg_q, neg_r, go, sgn, a_neg, b_neg, div0, ovf, special;
  // Decode request, operand magnitudes, special cases and one shift-subtract step
  always_comb begin
    go      = start & funct3[2];
    sgn     = ~funct3[0];
    a_neg   = sgn & rs1_value[31];
    b_neg   = sgn & rs2_value[31];
    a_mag   = a_neg ? -rs1_value : rs1_value;
    b_mag   = b_neg ? -rs2_value : rs2_value;
    div0    = rs2_value == 32'd0;
    ovf     = sgn & (rs1_value == 32'h8000_0000) & (rs2_value == 32'hFFFF_FFFF);
    special = div0 | ovf;
    shifted = {r, q[31]};
    diff    = shifted - {1'b0, d};
    fin_q   = neg_q ? -q : q;
    fin_r   = neg_r ? -r : r;
  end
  // State register
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else     state <= next_state;
  // Next-state logic; special cases skip CALC entirely
  always_comb
    next_state = state == IDLE ? (go ? (special ? FIN : CALC) : IDLE) :
                 state == CALC ? (cnt == 5'd0 ? FIN : CALC) : IDLE;
  // FSM outputs
  always_comb busy = state != IDLE;
  // Datapath: capture operands, iterate, and register the write-back in FIN
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      q      <= '0;
      d      <= '0;
      r      <= '0;
      cnt    <= '0;
      rd_q   <= '0;
      is_rem <= 1'b0;
      neg_q  <= 1'b0;
      neg_r  <= 1'b0;
      done   <= 1'b0;
      wr_en  <= 1'b0;
      rd_out <= '0;
      result <= '0;
    end else begin
      done  <= state == FIN;
      wr_en <= (state == FIN) && (rd_q != 5'd0);
      if (state == IDLE && go) begin
        q      <= div0 ? 32'hFFFF_FFFF : ovf ? 32'h8000_0000 : a_mag;
        r      <= div0 ? rs1_value : 32'd0;
        d      <= b_mag;
        neg_q  <= ~special & (a_neg ^ b_neg);
        neg_r  <= ~special & a_neg;
        is_rem <= funct3[1];
        rd_q   <= rd_in;
        cnt    <= 5'd31;
      end else if (state == CALC) begin
        r   <= diff[32] ? shifted[31:0] : diff[31:0];
        q   <= {q[30:0], ~diff[32]};
        cnt <= cnt - 5'd1;
      end else if (state == FIN) begin
        result <= is_rem ? fin_r : fin_q;
        rd_out <= rd_q;
      end
    end
endmodule

// File: tb/tb_div_unit.sv
// tb_div_unit: table-driven and scoreboarded checks of div_unit results, latency and corner cases
module tb_div_unit;
  logic        clk = 1'b0, rst = 1'b1, start = 1'b0;
  logic [2:0]  funct3 = 3'b000;
  logic [31:0] rs1_value = '0, rs2_value = '0;
  logic [4:0]  rd_in = '0;
  logic        busy, done, wr_en;
  logic [4:0]  rd_out;
  logic [31:0] result;
  int tests = 0, failed = 0;

  typedef struct {
    logic [2:0]  f;
    logic [31:0] a, b;
    logic [4:0]  rd;
    logic [31:0] exp;
    int          lat;
  } vec_t;
  typedef struct {
    logic [31:0] res;
    logic [4:0]  rd;
    int          lat;
  } exp_t;
  exp_t sb[$];
  vec_t vecs[14];

  div_unit dut (
    .clk(clk), .rst(rst), .start(start), .funct3(funct3),
    .rs1_value(rs1_value), .rs2_value(rs2_value), .rd_in(rd_in),
    .busy(busy), .done(done), .wr_en(wr_en), .rd_out(rd_out), .result(result)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b, input logic [4:0] rd);
    @(negedge clk);
    funct3 = f; rs1_value = a; rs2_value = b; rd_in = rd; start = 1'b1;
  endtask

  task automatic wait_done(input string name);
    exp_t e;
    int n;
    n = 0;
    while (n < 60) begin
      @(posedge clk);
      n++;
      #1;
      if (done) break;
    end
    e = sb.pop_front();
    if (!done) begin
      chk({name, "_timeout"}, 32'd0, 32'd1);
      return;
    end
    chk({name, "_result"}, result, e.res);
    chk({name, "_rd"}, {27'd0, rd_out}, {27'd0, e.rd});
    chk({name, "_wr_en"}, {31'd0, wr_en}, {31'd0, e.rd != 5'd0});
    chk({name, "_latency"}, n, e.lat);
    @(posedge clk);
    #1;
    chk({name, "_done_pulse"}, {31'd0, done}, 32'd0);
    chk({name, "_idle"}, {31'd0, busy}, 32'd0);
  endtask

  task automatic run(input vec_t v, input string name);
    drive(v.f, v.a, v.b, v.rd);
    sb.push_back('{v.exp, v.rd, v.lat});
    @(posedge clk);
    #1;
    start = 1'b0;
    chk({name, "_busy"}, {31'd0, busy}, 32'd1);
    rs1_value = $urandom; rs2_value = $urandom; rd_in = 5'($urandom); funct3 = 3'($urandom);
    wait_done(name);
  endtask

  initial begin
    int n, pulses;
    vecs[0]  = '{3'b100, 32'd100,        32'd7,          5'd5,  32'd14,         33};
    vecs[1]  = '{3'b110, 32'd100,        32'd7,          5'd5,  32'd2,          33};
    vecs[2]  = '{3'b110, 32'hFFFF_FFF9,  32'd2,          5'd3,  32'hFFFF_FFFF,  33};
    vecs[3]  = '{3'b100, 32'hFFFF_FFF9,  32'd2,          5'd3,  32'hFFFF_FFFD,  33};
    vecs[4]  = '{3'b111, 32'hFFFF_FFF9,  32'd2,          5'd3,  32'd1,          33};
    vecs[5]  = '{3'b101, 32'd1234,       32'd0,          5'd7,  32'hFFFF_FFFF,  1};
    vecs[6]  = '{3'b111, 32'd1234,       32'd0,          5'd7,  32'd1234,       1};
    vecs[7]  = '{3'b100, 32'h8000_0000,  32'hFFFF_FFFF,  5'd8,  32'h8000_0000,  1};
    vecs[8]  = '{3'b110, 32'h8000_0000,  32'hFFFF_FFFF,  5'd8,  32'd0,          1};
    vecs[9]  = '{3'b100, 32'hFFFF_FFF9,  32'd0,          5'd9,  32'hFFFF_FFFF,  1};
    vecs[10] = '{3'b110, 32'hFFFF_FFF9,  32'd0,          5'd9,  32'hFFFF_FFF9,  1};
    vecs[11] = '{3'b101, 32'hFFFF_FFFF,  32'd1,          5'd31, 32'hFFFF_FFFF,  33};
    vecs[12] = '{3'b100, 32'd100,        32'd7,          5'd0,  32'd14,         33};
    vecs[13] = '{3'b101, 32'h8000_0000,  32'hFFFF_FFFF,  5'd2,  32'd0,          33};

    #12;
    chk("reset_busy", {31'd0, busy}, 32'd0);
    chk("reset_done", {31'd0, done}, 32'd0);
    chk("reset_wr_en", {31'd0, wr_en}, 32'd0);
    chk("reset_result", result, 32'd0);
    chk("reset_rd_out", {27'd0, rd_out}, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    drive(3'b001, 32'd5, 32'd1, 5'd4);
    @(posedge clk);
    #1;
    start = 1'b0;
    chk("noreq_busy", {31'd0, busy}, 32'd0);

    for (int i = 0; i < 14; i++) run(vecs[i], $sformatf("vec%0d", i));

    drive(3'b100, 32'd100, 32'd7, 5'd5);
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    chk("abort_busy", {31'd0, busy}, 32'd0);
    chk("abort_done", {31'd0, done}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    pulses = 0;
    repeat (40) begin
      @(posedge clk);
      #1;
      if (done) pulses++;
    end
    chk("abort_no_done", pulses, 0);
    run('{3'b101, 32'd9, 32'd3, 5'd6, 32'd3, 33}, "after_reset");

    drive(3'b100, 32'd100, 32'd7, 5'd5);
    sb.push_back('{32'd14, 5'd5, 33});
    @(posedge clk);
    #1;
    start = 1'b0;
    n = 0;
    pulses = 0;
    while (n < 80) begin
      @(posedge clk);
      n++;
      #1;
      start = 1'b0;
      if (done) begin
        pulses++;
        if (pulses == 1) begin
          exp_t e;
          e = sb.pop_front();
          chk("ignore_result", result, e.res);
          chk("ignore_latency", n, e.lat);
        end
      end
      if (n == 4 || n == 32) begin
        funct3 = 3'b101; rs1_value = 32'd1000; rs2_value = 32'd10; rd_in = 5'd9; start = 1'b1;
      end
    end
    chk("ignore_pulses", pulses, 1);
    chk("ignore_busy", {31'd0, busy}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end
endmodule

// File: doc/div_unit.md
DIV_UNIT -- requirements
Module: div_unit

Interface
REQ-001 Parameters SHALL be: none; the operand width SHALL be fixed at 32 bits.
REQ-002 clk  input  1  sole clock; all state SHALL update on the rising edge.
REQ-003 rst  input  1  reset; asynchronous, active-high.
REQ-004 start  input  1  request to begin a divide; sampled only in IDLE.
REQ-005 funct3  input  3  opcode select: 100 DIV, 101 DIVU, 110 REM, 111 REMU; 0xx SHALL be treated as no request.
REQ-006 rs1_value  input  32  dividend, from the register file read port 1.
REQ-007 rs2_value  input  32  divisor, from the register file read port 2.
REQ-008 rd_in  input  5  destination register index, captured with the operands.
REQ-009 busy  output  1  operation in progress; new start requests are ignored while high.
REQ-010 done  output  1  one-cycle pulse; result and rd_out are valid in this cycle.
REQ-011 wr_en  output  1  register file write enable; equals done AND (rd_out != 0).
REQ-012 rd_out  output  5  destination index for the register file write.
REQ-013 result  output  32  quotient or remainder for the register file rd_value input.

Function
REQ-014 The FSM SHALL have exactly three states: IDLE, CALC, FIN.
REQ-015 IDLE with start=1 and funct3[2]=1 at edge N: operands, funct3 and rd_in SHALL be latched, and busy SHALL be high from edge N.
REQ-016 From IDLE, the next state SHALL be FIN if the divisor is 0 or the operation is the signed overflow case; otherwise it SHALL be CALC with the iteration counter set to 31.
REQ-017 CALC SHALL run one restoring shift-subtract step per edge on 32-bit magnitudes, with a 33-bit partial remainder, and SHALL go to FIN after the step with counter 0 (32 steps, edges N+1..N+32).
REQ-018 Signed operations: magnitudes SHALL be used in CALC; quotient sign SHALL be sign(rs1) XOR sign(rs2); remainder sign SHALL be sign(rs1).
REQ-019 FIN SHALL drive result, rd_out and done=1 for one cycle, then return to IDLE with busy low on the following edge.
REQ-020 Normal latency: done SHALL be high in the cycle after edge N+33; special-case latency: done SHALL be high in the cycle after edge N+1.
REQ-021 Divide by zero: quotient SHALL be 0xFFFFFFFF (signed and unsigned); remainder SHALL be rs1_value.
REQ-022 Signed overflow (0x80000000 / 0xFFFFFFFF): quotient SHALL be 0x80000000; remainder SHALL be 0.
REQ-023 start while busy, including during the FIN cycle, SHALL be ignored and SHALL not be queued.
REQ-024 Operand inputs SHALL be ignored after capture; changing them mid-operation SHALL not affect the result.
REQ-025 rd_in=0: the operation SHALL complete with a done pulse, and wr_en SHALL stay 0.
REQ-026 Outside FIN, done and wr_en SHALL be 0; result and rd_out SHALL hold their last values.

Reset
REQ-027 rst=1 SHALL immediately force state to IDLE, and busy, done, wr_en, rd_out, result, the counter and all datapath registers to 0.
REQ-028 rst asserted mid-operation SHALL abort the operation with no done pulse; the first start after rst deasserts SHALL be accepted normally.

Verification
REQ-029 DIV 100/7, rd=5 -> done and wr_en after edge N+33, result=14, rd_out=5; REM of the same operands -> result=2.
REQ-030 REM 0xFFFFFFF9 (-7) by 2 -> 0xFFFFFFFF (-1); DIV with the same operands -> 0xFFFFFFFD (-3); REMU 0xFFFFFFF9 by 2 -> 1.
REQ-031 DIVU 1234/0 -> result 0xFFFFFFFF after edge N+1; REMU 1234/0 -> 1234; DIV 0x80000000/0xFFFFFFFF -> 0x80000000; REM of the same operands -> 0.
REQ-032 Assert rst at cycle 10 of a DIV -> busy=0 immediately and no done pulse; a new DIVU 9/3 afterwards -> 3 at normal latency.
REQ-033 start pulsed at cycle 5 and in the FIN cycle of a running DIV -> ignored, exactly one done pulse; rd_in=0 -> done=1 with wr_en=0.
